// File: rtl/retire_pkg.sv
// Shared types and decode helpers for the retire tracker: record layout, opcodes, J-immediate.
// The record payload width is fixed by REC_XLEN; the tracker's XLEN parameter must match it.
package retire_pkg;

    localparam int unsigned REC_XLEN = 32;
    localparam int unsigned ORDER_W  = 64;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [ORDER_W-1:0]  order;
        logic [REC_XLEN-1:0] pc;
        logic [REC_XLEN-1:0] next_pc;
        logic [31:0]         insn;
        logic [4:0]          rd;
        logic [REC_XLEN-1:0] wdata;
    } retire_rec_t;

    // Sign-extended J-type immediate (bit 0 always zero).
    function automatic logic [REC_XLEN-1:0] j_imm(input logic [31:0] insn);
        return {{(REC_XLEN-20){insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/retire_tracker_if.sv
// Retire record stream: valid/ready handshake plus record payload at the FIFO head.
interface retire_tracker_if #(
    parameter int unsigned XLEN = 32
);
    logic            retire_valid_o;
    logic            retire_ready_i;
    logic [63:0]     retire_order_o;
    logic [XLEN-1:0] retire_pc_o;
    logic [XLEN-1:0] retire_next_pc_o;
    logic [31:0]     retire_insn_o;
    logic [4:0]      retire_rd_o;
    logic [XLEN-1:0] retire_rd_wdata_o;

    modport master (
        output retire_valid_o, retire_order_o, retire_pc_o, retire_next_pc_o,
               retire_insn_o, retire_rd_o, retire_rd_wdata_o,
        input  retire_ready_i
    );

    modport slave (
        input  retire_valid_o, retire_order_o, retire_pc_o, retire_next_pc_o,
               retire_insn_o, retire_rd_o, retire_rd_wdata_o,
        output retire_ready_i
    );
endinterface

// File: rtl/retire_fifo.sv
// DEPTH-entry FIFO of retire records; a push while full is accepted only with a same-cycle pop.
module retire_fifo
    import retire_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  retire_rec_t push_data,
    input  logic        pop,
    output retire_rec_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    retire_rec_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/retire_tracker.sv
// Retire record generator behind WB: one-entry hold resolves next_pc, records queue in a FIFO.
// Optional RETIRE_CF_CHECK_EN adds the expected-pc tracker driving cf_error_o.
module retire_tracker
    import retire_pkg::*;
#(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     DEPTH   = 4,
    parameter logic [XLEN-1:0] PC_INIT = 'h200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid_i,
    input  logic [XLEN-1:0]  wb_pc_i,
    input  logic [31:0]      wb_insn_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [XLEN-1:0]  wb_value_i,
    retire_tracker_if.master ret,
    output logic             overflow_o,
    output logic             cf_error_o
);

    logic               hold_valid;
    logic [XLEN-1:0]    hold_pc;
    logic [31:0]        hold_insn;
    logic [4:0]         hold_rd;
    logic [XLEN-1:0]    hold_wdata;
    logic [ORDER_W-1:0] order_q;
    logic               overflow_q;

    logic [4:0]         rd_norm;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    retire_rec_t        push_rec;
    retire_rec_t        head;

    assign rd_norm = (wb_we_i && (wb_rd_i != 5'd0)) ? wb_rd_i : 5'd0;
    assign push    = wb_valid_i && hold_valid;
    assign pop     = !empty && ret.retire_ready_i;

    assign push_rec = '{order:   order_q,
                        pc:      hold_pc,
                        next_pc: wb_pc_i,
                        insn:    hold_insn,
                        rd:      hold_rd,
                        wdata:   hold_wdata};

    // Hold stage waits for the successor pc; order advances even when the record is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_pc    <= '0;
            hold_insn  <= '0;
            hold_rd    <= '0;
            hold_wdata <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wb_valid_i) begin
                hold_valid <= 1'b1;
                hold_pc    <= wb_pc_i;
                hold_insn  <= wb_insn_i;
                hold_rd    <= rd_norm;
                hold_wdata <= (rd_norm == 5'd0) ? '0 : wb_value_i;
            end
            if (push) begin
                order_q <= order_q + ORDER_W'(1);
                if (full && !pop) overflow_q <= 1'b1;
            end
        end
    end

    retire_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign ret.retire_valid_o    = !empty;
    assign ret.retire_order_o    = head.order;
    assign ret.retire_pc_o       = head.pc;
    assign ret.retire_next_pc_o  = head.next_pc;
    assign ret.retire_insn_o     = head.insn;
    assign ret.retire_rd_o       = head.rd;
    assign ret.retire_rd_wdata_o = head.wdata;
    assign overflow_o            = overflow_q;

`ifdef RETIRE_CF_CHECK_EN
    logic [XLEN-1:0] exp_pc;
    logic            exp_valid;
    logic            cf_error_q;

    // Branch/jalr targets are not predicted, so they leave the expectation undefined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_pc     <= PC_INIT;
            exp_valid  <= 1'b1;
            cf_error_q <= 1'b0;
        end else if (wb_valid_i) begin
            if (exp_valid && (wb_pc_i != exp_pc)) cf_error_q <= 1'b1;
            case (wb_insn_i[6:0])
                OPC_JAL: begin
                    exp_pc    <= (wb_pc_i + j_imm(wb_insn_i)) & ~XLEN'(3);
                    exp_valid <= 1'b1;
                end
                OPC_BRANCH, OPC_JALR: begin
                    exp_valid <= 1'b0;
                end
                default: begin
                    exp_pc    <= wb_pc_i + XLEN'(4);
                    exp_valid <= 1'b1;
                end
            endcase
        end
    end

    assign cf_error_o = cf_error_q;
`else
    assign cf_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_retire_tracker.sv
// Directed self-checking bench for retire_tracker; cf_error expectations follow RETIRE_CF_CHECK_EN.
module tb_retire_tracker;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
`ifdef RETIRE_CF_CHECK_EN
    localparam logic CF_EN = 1'b1;
`else
    localparam logic CF_EN = 1'b0;
`endif

    localparam logic [31:0] ADDI  = 32'h00108093;
    localparam logic [31:0] JAL16 = 32'h010000EF;
    localparam logic [31:0] JALR  = 32'h000080E7;
    localparam logic [31:0] BEQ   = 32'h00000063;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_insn = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_value = '0;
    logic        overflow;
    logic        cf_error;

    int n_checks = 0;
    int n_fail   = 0;

    retire_tracker_if #(.XLEN(XLEN)) rif ();

    retire_tracker #(.XLEN(XLEN), .DEPTH(DEPTH), .PC_INIT(32'h200)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid_i (wb_valid),
        .wb_pc_i    (wb_pc),
        .wb_insn_i  (wb_insn),
        .wb_we_i    (wb_we),
        .wb_rd_i    (wb_rd),
        .wb_value_i (wb_value),
        .ret        (rif),
        .overflow_o (overflow),
        .cf_error_o (cf_error)
    );

    always #5 clk = ~clk;

    // Head snapshot: {valid, order, pc, next_pc, insn, rd, wdata}
    logic [197:0] got;
    assign got = {rif.retire_valid_o, rif.retire_order_o, rif.retire_pc_o, rif.retire_next_pc_o,
                  rif.retire_insn_o, rif.retire_rd_o, rif.retire_rd_wdata_o};

    task automatic do_reset();
        rst_n = 1'b0;
        wb_valid = 1'b0;
        rif.retire_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic we,
                          input logic [4:0] rd, input logic [31:0] value);
        wb_valid = 1'b1;
        wb_pc    = pc;
        wb_insn  = insn;
        wb_we    = we;
        wb_rd    = rd;
        wb_value = value;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [199:0] exp0;
        rst_n = 1'b0;
        rif.retire_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp0 = '0;
        n_checks++;
        if ({got, overflow, cf_error} !== exp0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", {got, overflow, cf_error}, exp0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sequential();
        logic [197:0] exp;
        do_reset();
        retire(32'h200, ADDI, 1'b1, 5'd1, 32'd1);
        @(negedge clk);
        n_checks++;
        if (rif.retire_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_no_record_yet: got valid %b expected 0", rif.retire_valid_o);
        end
        retire(32'h204, ADDI, 1'b1, 5'd1, 32'd2);
        @(negedge clk);
        exp = {1'b1, 64'd0, 32'h200, 32'h204, ADDI, 5'd1, 32'd1};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL seq_rec0: got %h expected %h", got, exp);
        end
        retire(32'h208, ADDI, 1'b1, 5'd1, 32'd3);
        @(negedge clk);
        exp = {1'b1, 64'd1, 32'h204, 32'h208, ADDI, 5'd1, 32'd2};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL seq_rec1: got %h expected %h", got, exp);
        end
        @(negedge clk);
        n_checks++;
        if ({rif.retire_valid_o, cf_error} !== 2'b00) begin
            n_fail++;
            $display("FAIL seq_drained: got valid/cf %b%b expected 00", rif.retire_valid_o, cf_error);
        end
    endtask

    task automatic test_jal();
        logic [197:0] exp;
        do_reset();
        retire(32'h200, JAL16, 1'b1, 5'd1, 32'h204);
        retire(32'h210, ADDI, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        exp = {1'b1, 64'd0, 32'h200, 32'h210, JAL16, 5'd1, 32'h204};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL jal_rec: got %h expected %h", got, exp);
        end
        n_checks++;
        if (cf_error !== 1'b0) begin
            n_fail++;
            $display("FAIL jal_target_ok: got cf %b expected 0", cf_error);
        end
        do_reset();
        retire(32'h200, JAL16, 1'b1, 5'd1, 32'h204);
        retire(32'h204, ADDI, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++;
        if (cf_error !== CF_EN) begin
            n_fail++;
            $display("FAIL jal_target_bad: got cf %b expected %b", cf_error, CF_EN);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (cf_error !== CF_EN) begin
            n_fail++;
            $display("FAIL cf_sticky: got cf %b expected %b", cf_error, CF_EN);
        end
    endtask

    task automatic test_rd_norm();
        logic [197:0] exp;
        do_reset();
        retire(32'h200, ADDI, 1'b1, 5'd0, 32'h55);
        retire(32'h204, ADDI, 1'b1, 5'd3, 32'h33);
        @(negedge clk);
        exp = {1'b1, 64'd0, 32'h200, 32'h204, ADDI, 5'd0, 32'd0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL rd_x0_write: got %h expected %h", got, exp);
        end
        retire(32'h208, ADDI, 1'b0, 5'd5, 32'h77);
        @(negedge clk);
        exp = {1'b1, 64'd1, 32'h204, 32'h208, ADDI, 5'd3, 32'h33};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL rd_real_write: got %h expected %h", got, exp);
        end
        retire(32'h20C, ADDI, 1'b1, 5'd0, 32'd0);
        @(negedge clk);
        exp = {1'b1, 64'd2, 32'h208, 32'h20C, ADDI, 5'd0, 32'd0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL rd_no_we: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_overflow();
        logic [197:0] exp;
        do_reset();
        rif.retire_ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            retire(32'h200 + 32'(4 * i), ADDI, 1'b1, 5'd1, 32'(i));
            if (i == DEPTH) begin
                @(negedge clk);
                n_checks++;
                if (overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_full_no_drop: got %b expected 0", overflow);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if ({overflow, rif.retire_valid_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf/valid %b%b expected 11", overflow, rif.retire_valid_o);
        end
        exp = {1'b1, 64'd0, 32'h200, 32'h204, ADDI, 5'd1, 32'd0};
        @(negedge clk);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ovf_head_stable: got %h expected %h", got, exp);
        end
        rif.retire_ready_i = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            exp = {1'b1, 64'(k), 32'h200 + 32'(4 * k), 32'h204 + 32'(4 * k), ADDI, 5'd1, 32'(k)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: got %h expected %h", k, got, exp);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({rif.retire_valid_o, overflow} !== 2'b01) begin
            n_fail++;
            $display("FAIL ovf_empty_sticky: got valid/ovf %b%b expected 01", rif.retire_valid_o, overflow);
        end
        retire(32'h218, ADDI, 1'b1, 5'd1, 32'd6);
        @(negedge clk);
        exp = {1'b1, 64'd5, 32'h214, 32'h218, ADDI, 5'd1, 32'd5};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ovf_order_gap: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_branch();
        logic [197:0] exp;
        do_reset();
        retire(32'h200, JALR, 1'b1, 5'd1, 32'h204);
        retire(32'h300, BEQ, 1'b0, 5'd0, 32'd0);
        retire(32'h400, ADDI, 1'b1, 5'd1, 32'd9);
        @(negedge clk);
        exp = {1'b1, 64'd1, 32'h300, 32'h400, BEQ, 5'd0, 32'd0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL branch_rec: got %h expected %h", got, exp);
        end
        n_checks++;
        if (cf_error !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_no_cf: got cf %b expected 0", cf_error);
        end
    endtask

    task automatic test_mid_reset();
        logic [197:0] exp;
        do_reset();
        rif.retire_ready_i = 1'b0;
        retire(32'h200, ADDI, 1'b1, 5'd1, 32'd1);
        retire(32'h204, ADDI, 1'b1, 5'd1, 32'd2);
        retire(32'h208, ADDI, 1'b1, 5'd1, 32'd3);
        @(negedge clk);
        n_checks++;
        if (rif.retire_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mrst_before: got valid %b expected 1", rif.retire_valid_o);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rif.retire_valid_o, rif.retire_order_o, rif.retire_pc_o} !== 97'd0) begin
            n_fail++;
            $display("FAIL mrst_immediate: got %h expected 0",
                     {rif.retire_valid_o, rif.retire_order_o, rif.retire_pc_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        rif.retire_ready_i = 1'b1;
        retire(32'h200, ADDI, 1'b1, 5'd2, 32'hA);
        retire(32'h204, ADDI, 1'b1, 5'd2, 32'hB);
        @(negedge clk);
        exp = {1'b1, 64'd0, 32'h200, 32'h204, ADDI, 5'd2, 32'hA};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL mrst_first_rec: got %h expected %h", got, exp);
        end
    endtask

    initial begin
        rif.retire_ready_i = 1'b0;
        test_reset();
        test_sequential();
        test_jal();
        test_rd_norm();
        test_overflow();
        test_branch();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
